// File: rtl/avalon_encoder_poller.sv
// Avalon-MM read master that polls an encoder count at a fixed rate and
// publishes position plus per-period velocity with a one-cycle strobe.
//
// state  | meaning
// IDLE   | waiting for the period tick; clears has_prev while disabled
// READ   | avm_read held until waitrequest drops, readdata captured then
// UPDATE | position/velocity written, sample_valid raised next cycle
module avalon_encoder_poller #(
  parameter int unsigned POLL_PERIOD = 50000,
  parameter int unsigned TIMEOUT     = 16,
  parameter logic [0:0]  COUNT_ADDR  = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic [31:0] position,
  output logic [31:0] velocity,
  output logic        sample_valid,
  output logic        timeout_err,
  output logic        overrun_err,
  input  logic        clear_err
);

  localparam int PW = $clog2(POLL_PERIOD);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(POLL_PERIOD - 1);
  localparam int SW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STALL_LIMIT = SW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, READ, UPDATE} state_t;

  state_t        state;
  logic [PW-1:0] period_cnt;
  logic [SW-1:0] stall_cnt;
  logic [31:0]   captured;
  logic          has_prev;

  logic tick;
  logic stall;
  logic timeout_hit;
  logic overrun_hit;

  assign tick        = enable && (period_cnt == PERIOD_LAST);
  assign stall       = (state == READ) && avm_waitrequest;
  assign timeout_hit = stall && (stall_cnt == STALL_LIMIT - SW'(1));
  assign overrun_hit = tick && (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      period_cnt   <= '0;
      stall_cnt    <= '0;
      captured     <= '0;
      has_prev     <= 1'b0;
      avm_address  <= COUNT_ADDR;
      avm_read     <= 1'b0;
      position     <= '0;
      velocity     <= '0;
      sample_valid <= 1'b0;
      timeout_err  <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      // Free-running period counter keeps the sample rate independent of slave latency
      if (!enable || period_cnt == PERIOD_LAST) period_cnt <= '0;
      else                                      period_cnt <= period_cnt + PW'(1);

      avm_address  <= COUNT_ADDR;
      sample_valid <= 1'b0;
      timeout_err  <= timeout_hit | (timeout_err & ~clear_err);
      overrun_err  <= overrun_hit | (overrun_err & ~clear_err);

      case (state)
        IDLE: begin
          if (!enable) has_prev <= 1'b0;
          if (tick) begin
            state     <= READ;
            avm_read  <= 1'b1;
            stall_cnt <= '0;
          end
        end
        READ: begin
          if (!avm_waitrequest) begin
            captured <= avm_readdata;
            avm_read <= 1'b0;
            state    <= UPDATE;
          end else if (stall_cnt != STALL_LIMIT) begin
            stall_cnt <= stall_cnt + SW'(1);
          end
        end
        UPDATE: begin
          position     <= captured;
          velocity     <= has_prev ? (captured - position) : 32'd0;
          has_prev     <= 1'b1;
          sample_valid <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_encoder_poller.sv
// Bench for avalon_encoder_poller: scripted slave with per-read wait counts,
// sample monitor, and a sample-sequence model of position/velocity.
module tb_avalon_encoder_poller;

  localparam int P  = 8;
  localparam int TO = 16;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic [31:0] position;
  logic [31:0] velocity;
  logic        sample_valid;
  logic        timeout_err;
  logic        overrun_err;
  logic        clear_err;

  avalon_encoder_poller #(.POLL_PERIOD(P), .TIMEOUT(TO), .COUNT_ADDR(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .position(position), .velocity(velocity), .sample_valid(sample_valid),
    .timeout_err(timeout_err), .overrun_err(overrun_err), .clear_err(clear_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          c;
    logic [31:0] pos;
    logic [31:0] vel;
  } samp_t;

  samp_t       samp_q[$];
  int          rise_q[$];
  logic        prev_read = 1'b0;
  logic [31:0] data_q[$];
  int          wait_q[$];
  int          wleft = 1;

  always @(negedge clk) begin
    if (!reset_n) prev_read <= 1'b0;
    else begin
      if (sample_valid) samp_q.push_back(samp_t'{c: cyc, pos: position, vel: velocity});
      if (avm_read && !prev_read) rise_q.push_back(cyc);
      prev_read <= avm_read;
    end
  end

  // Slave: stalls each read for its scripted count, then returns the next word
  initial begin
    avm_waitrequest = 1'b1;
    avm_readdata    = 32'd0;
    forever begin
      @(negedge clk);
      if (reset_n && avm_read) begin
        if (wleft > 0) begin
          avm_waitrequest = 1'b1;
          wleft--;
        end else begin
          avm_waitrequest = 1'b0;
          avm_readdata = (data_q.size() > 0) ? data_q.pop_front() : 32'hDEAD0000;
          if (wait_q.size() > 0) void'(wait_q.pop_front());
        end
      end else begin
        avm_waitrequest = 1'b1;
        wleft = (wait_q.size() > 0) ? wait_q[0] : 1;
      end
    end
  end

  // Model: velocity is the 32-bit difference to the previous sample of the session
  logic [31:0] m_prev = 32'd0;
  bit          m_has  = 1'b0;

  function automatic logic [31:0] model_step(input logic [31:0] d);
    logic [31:0] v;
    v = m_has ? (d - m_prev) : 32'd0;
    m_prev = d;
    m_has  = 1'b1;
    return v;
  endfunction

  task automatic wait_samples(input int n, input int budget);
    int k = 0;
    while (samp_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (samp_q.size() < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL sample_wait: got %0d samples, required %0d", samp_q.size(), n);
    end
  endtask

  task automatic wait_rises(input int n, input int budget);
    int k = 0;
    while (rise_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (rise_q.size() < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL read_wait: got %0d reads, required %0d", rise_q.size(), n);
    end
  endtask

  task automatic new_session();
    samp_q.delete();
    rise_q.delete();
    data_q.delete();
    wait_q.delete();
    m_has = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; clear_err = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (avm_read !== 1'b0) begin n_fail++; $display("FAIL rst_read: got %b expected 0", avm_read); end
    n_checks++; if (avm_address !== 1'b0) begin n_fail++; $display("FAIL rst_addr: got %b expected 0", avm_address); end
    n_checks++; if (position !== 32'd0) begin n_fail++; $display("FAIL rst_pos: got %0h expected 0", position); end
    n_checks++; if (velocity !== 32'd0) begin n_fail++; $display("FAIL rst_vel: got %0h expected 0", velocity); end
    n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", sample_valid); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_tmo: got %b expected 0", timeout_err); end
    n_checks++; if (overrun_err !== 1'b0) begin n_fail++; $display("FAIL rst_ovr: got %b expected 0", overrun_err); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] vals [3];
    logic [31:0] ev;
    int en_cyc;
    vals[0] = 32'd100; vals[1] = 32'd130; vals[2] = 32'd90;
    new_session();
    for (int i = 0; i < 3; i++) begin data_q.push_back(vals[i]); wait_q.push_back(1); end
    @(negedge clk);
    en_cyc = cyc;
    enable = 1'b1;
    wait_samples(3, 60);
    enable = 1'b0;
    if (rise_q.size() > 0) begin
      n_checks++;
      if (rise_q[0] - en_cyc != P) begin n_fail++; $display("FAIL basic_first_read: got %0d cycles expected %0d", rise_q[0] - en_cyc, P); end
    end
    if (samp_q.size() > 0 && rise_q.size() > 0) begin
      n_checks++;
      if (samp_q[0].c - rise_q[0] != 3) begin n_fail++; $display("FAIL basic_latency: got %0d expected 3", samp_q[0].c - rise_q[0]); end
    end
    for (int i = 0; i < 3 && i < samp_q.size(); i++) begin
      ev = model_step(vals[i]);
      n_checks++; if (samp_q[i].pos !== vals[i]) begin n_fail++; $display("FAIL basic_pos[%0d]: got %0d expected %0d", i, $signed(samp_q[i].pos), $signed(vals[i])); end
      n_checks++; if (samp_q[i].vel !== ev) begin n_fail++; $display("FAIL basic_vel[%0d]: got %0d expected %0d", i, $signed(samp_q[i].vel), $signed(ev)); end
      if (i > 0) begin
        n_checks++;
        if (samp_q[i].c - samp_q[i-1].c != P) begin n_fail++; $display("FAIL basic_spacing[%0d]: got %0d expected %0d", i, samp_q[i].c - samp_q[i-1].c, P); end
      end
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_count_wrap();
    logic [31:0] vals [2];
    logic [31:0] ev;
    vals[0] = 32'h7FFF_FFFE; vals[1] = 32'h8000_0001;
    new_session();
    data_q.push_back(vals[0]); wait_q.push_back(0);
    data_q.push_back(vals[1]); wait_q.push_back(2);
    @(negedge clk);
    enable = 1'b1;
    wait_samples(2, 60);
    enable = 1'b0;
    for (int i = 0; i < 2 && i < samp_q.size(); i++) begin
      ev = model_step(vals[i]);
      n_checks++; if (samp_q[i].pos !== vals[i]) begin n_fail++; $display("FAIL wrap_pos[%0d]: got %0h expected %0h", i, samp_q[i].pos, vals[i]); end
      n_checks++; if (samp_q[i].vel !== ev) begin n_fail++; $display("FAIL wrap_vel[%0d]: got %0d expected %0d", i, $signed(samp_q[i].vel), $signed(ev)); end
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] vals [6];
    int          waits [6];
    logic [31:0] ev;
    new_session();
    for (int i = 0; i < 6; i++) begin
      vals[i]  = $urandom;
      waits[i] = $urandom_range(0, 3);
      data_q.push_back(vals[i]);
      wait_q.push_back(waits[i]);
    end
    @(negedge clk);
    enable = 1'b1;
    wait_samples(6, 100);
    enable = 1'b0;
    for (int i = 0; i < 6 && i < samp_q.size() && i < rise_q.size(); i++) begin
      ev = model_step(vals[i]);
      n_checks++; if (samp_q[i].pos !== vals[i]) begin n_fail++; $display("FAIL rand_pos[%0d]: got %0h expected %0h", i, samp_q[i].pos, vals[i]); end
      n_checks++; if (samp_q[i].vel !== ev) begin n_fail++; $display("FAIL rand_vel[%0d]: got %0h expected %0h", i, samp_q[i].vel, ev); end
      n_checks++; if (samp_q[i].c - rise_q[i] != waits[i] + 2) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, samp_q[i].c - rise_q[i], waits[i] + 2); end
      if (i > 0) begin
        n_checks++;
        if (rise_q[i] - rise_q[i-1] != P) begin n_fail++; $display("FAIL rand_rate[%0d]: got %0d expected %0d", i, rise_q[i] - rise_q[i-1], P); end
      end
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_enable_drop();
    logic [31:0] vals [3];
    logic [31:0] ev;
    int en2;
    vals[0] = 32'd5000; vals[1] = 32'd4321; vals[2] = 32'd77;
    new_session();
    data_q.push_back(vals[0]); wait_q.push_back(1);
    data_q.push_back(vals[1]); wait_q.push_back(3);
    data_q.push_back(vals[2]); wait_q.push_back(1);
    @(negedge clk);
    enable = 1'b1;
    wait_samples(1, 40);
    wait_rises(2, 40);
    enable = 1'b0;
    n_checks++; if (avm_read !== 1'b1) begin n_fail++; $display("FAIL drop_read_active: got %b expected 1", avm_read); end
    wait_samples(2, 20);
    repeat (20) @(negedge clk);
    n_checks++; if (samp_q.size() != 2) begin n_fail++; $display("FAIL drop_samples: got %0d expected 2", samp_q.size()); end
    n_checks++; if (rise_q.size() != 2) begin n_fail++; $display("FAIL drop_reads: got %0d expected 2", rise_q.size()); end
    for (int i = 0; i < 2 && i < samp_q.size(); i++) begin
      ev = model_step(vals[i]);
      n_checks++; if (samp_q[i].vel !== ev) begin n_fail++; $display("FAIL drop_vel[%0d]: got %0d expected %0d", i, $signed(samp_q[i].vel), $signed(ev)); end
    end
    n_checks++; if (position !== vals[1]) begin n_fail++; $display("FAIL drop_pos_hold: got %0d expected %0d", position, vals[1]); end
    m_has = 1'b0;
    en2 = cyc;
    enable = 1'b1;
    wait_samples(3, 40);
    enable = 1'b0;
    if (rise_q.size() > 2) begin
      n_checks++;
      if (rise_q[2] - en2 != P) begin n_fail++; $display("FAIL reenable_first_read: got %0d expected %0d", rise_q[2] - en2, P); end
    end
    if (samp_q.size() > 2) begin
      ev = model_step(vals[2]);
      n_checks++; if (samp_q[2].vel !== ev) begin n_fail++; $display("FAIL reenable_vel: got %0d expected %0d", $signed(samp_q[2].vel), $signed(ev)); end
      n_checks++; if (samp_q[2].pos !== vals[2]) begin n_fail++; $display("FAIL reenable_pos: got %0d expected %0d", samp_q[2].pos, vals[2]); end
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_overrun();
    new_session();
    data_q.push_back(32'd2024); wait_q.push_back(10);
    @(negedge clk);
    enable = 1'b1;
    wait_samples(1, 60);
    enable = 1'b0;
    n_checks++; if (overrun_err !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b expected 1", overrun_err); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL ovr_no_tmo: got %b expected 0", timeout_err); end
    repeat (20) @(negedge clk);
    n_checks++; if (samp_q.size() != 1) begin n_fail++; $display("FAIL ovr_one_sample: got %0d expected 1", samp_q.size()); end
    n_checks++; if (position !== 32'd2024) begin n_fail++; $display("FAIL ovr_pos: got %0d expected 2024", position); end
    // Clear the overrun flag so the timeout scenario starts from known flags
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int r;
    new_session();
    data_q.push_back(32'hCAFE_0001); wait_q.push_back(20);
    @(negedge clk);
    enable = 1'b1;
    wait_rises(1, 30);
    r = (rise_q.size() > 0) ? rise_q[0] : cyc;
    while (cyc < r + TO - 2) @(negedge clk);
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b expected 0", timeout_err); end
    while (cyc < r + TO) @(negedge clk);
    n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_set: got %b expected 1", timeout_err); end
    while (cyc < r + 19) @(negedge clk);
    n_checks++; if (avm_read !== 1'b1) begin n_fail++; $display("FAIL tmo_read_held: got %b expected 1", avm_read); end
    wait_samples(1, 20);
    enable = 1'b0;
    if (samp_q.size() > 0) begin
      n_checks++; if (samp_q[0].pos !== 32'hCAFE_0001) begin n_fail++; $display("FAIL tmo_pos: got %0h expected cafe0001", samp_q[0].pos); end
      n_checks++; if (samp_q[0].c - r != 22) begin n_fail++; $display("FAIL tmo_complete: got %0d expected 22", samp_q[0].c - r); end
    end
    repeat (12) @(negedge clk);
    n_checks++; if (samp_q.size() != 1) begin n_fail++; $display("FAIL tmo_one_sample: got %0d expected 1", samp_q.size()); end
  endtask

  task automatic test_clear_err();
    n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL clr_tmo_sticky: got %b expected 1", timeout_err); end
    n_checks++; if (overrun_err !== 1'b1) begin n_fail++; $display("FAIL clr_ovr_sticky: got %b expected 1", overrun_err); end
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL clr_tmo: got %b expected 0", timeout_err); end
    n_checks++; if (overrun_err !== 1'b0) begin n_fail++; $display("FAIL clr_ovr: got %b expected 0", overrun_err); end
    @(negedge clk);
  endtask

  task automatic test_reset_midread();
    new_session();
    data_q.push_back(32'h1234_5678); wait_q.push_back(30);
    @(negedge clk);
    enable = 1'b1;
    wait_rises(1, 30);
    repeat (3) @(negedge clk);
    n_checks++; if (avm_read !== 1'b1) begin n_fail++; $display("FAIL mid_read_active: got %b expected 1", avm_read); end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (avm_read !== 1'b0) begin n_fail++; $display("FAIL mid_rst_read: got %b expected 0", avm_read); end
    n_checks++; if (position !== 32'd0) begin n_fail++; $display("FAIL mid_rst_pos: got %0h expected 0", position); end
    n_checks++; if (velocity !== 32'd0) begin n_fail++; $display("FAIL mid_rst_vel: got %0h expected 0", velocity); end
    n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b expected 0", sample_valid); end
    enable = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    new_session();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    enable = 1'b0;
    clear_err = 1'b0;
    test_reset();
    test_basic();
    test_count_wrap();
    test_random();
    test_enable_drop();
    test_overrun();
    test_timeout();
    test_clear_err();
    test_reset_midread();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/avalon_encoder_poller.md
Name: avalon_encoder_poller

Overview:
- Avalon-MM read master that periodically polls an encoder count slave at address COUNT_ADDR, fully honouring waitrequest.
- Each completed read publishes the sampled position and a signed per-period delta (velocity) to the motor-control fabric, with a one-cycle strobe.
- Sits between the encoder slave and the speed controller, replacing HPS software polling.

Parameters:
- POLL_PERIOD, 50000, clock cycles between read issues; legal range 4..2^24.
- TIMEOUT, 16, consecutive waitrequest-high cycles in one read before timeout_err sets.
- COUNT_ADDR, 0, 1-bit word address driven during reads.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  polling enable
- avm_address  out  1  Avalon address
- avm_read  out  1  Avalon read request
- avm_readdata  in  32  signed count from slave
- avm_waitrequest  in  1  slave stall
- position  out  32  signed last sampled count
- velocity  out  32  signed position delta over one period
- sample_valid  out  1  one-cycle strobe when position/velocity update
- timeout_err  out  1  sticky; set on slave stall timeout
- overrun_err  out  1  sticky; set when a period tick lands during an active read
- clear_err  in  1  synchronous clear of both sticky flags

Behaviour:
- Reset (async, reset_n=0): avm_read=0, avm_address=COUNT_ADDR, position=0, velocity=0, sample_valid=0, timeout_err=0, overrun_err=0, period counter=0, has_prev=0, state=IDLE.
- Period counter: increments every cycle while enable=1 and wraps from POLL_PERIOD-1 to 0; the wrap cycle is the tick. Counter runs in every state, so the sample rate is fixed.
- States:
  - IDLE: on tick, go to READ; avm_read=1 from the next cycle.
  - READ: avm_read=1 and avm_address=COUNT_ADDR held constant.
    - Transfer completes in the first cycle with avm_read=1 and avm_waitrequest=0; avm_readdata is captured in that cycle.
    - Next state is UPDATE, and avm_read drops to 0 in the following cycle.
  - UPDATE (1 cycle):
    - position <= captured value.
    - velocity <= captured minus previous position, modulo 2^32. A count wrap from 0x7FFFFFFF to 0x80000000 yields +1.
    - If has_prev=0, velocity <= 0 and has_prev <= 1.
    - sample_valid=1 during this cycle only; return to IDLE.
- Minimum read latency: tick to avm_read is 1 cycle; with the encoder slave's one-cycle wait, tick to sample_valid is 4 cycles.
- Timeout: the stall counter counts waitrequest-high cycles in READ. When it reaches TIMEOUT, timeout_err=1.
  - avm_read stays asserted, as Avalon forbids withdrawal; completion then proceeds normally.
  - The stall counter clears on entering READ.
- Overrun: a tick while in READ or UPDATE sets overrun_err; that tick is dropped and no queueing occurs.
- Flags: clear_err=1 clears both sticky flags next cycle. A set condition in the same cycle wins, so the flag stays 1.
- enable=0:
  - Counter is held at 0 and no new reads are issued.
  - A read already in progress completes, including UPDATE and sample_valid.
  - has_prev is cleared once in IDLE, so the first sample after re-enable reports velocity=0.
  - position holds its last value.
- After re-enable, the first read is issued POLL_PERIOD cycles later.
- Reset asserted mid-read: immediate return to reset values with avm_read=0.
- All outputs are registered.

Test Plan:
- POLL_PERIOD=8; slave returns 100, then 130, then 90 with one wait cycle each -> three sample_valid pulses 8 cycles apart; velocity = 0, +30, -40; position = 100, 130, 90.
- Count wrap: samples 0x7FFFFFFE then 0x80000001 -> velocity=+3.
- Slave holds waitrequest for 20 cycles with TIMEOUT=16 -> timeout_err rises on the 16th stall cycle; avm_read stays high; completion on cycle 21 still updates position.
- Slave stalls longer than POLL_PERIOD -> overrun_err=1, exactly one sample for that read; clear_err -> both flags 0 next cycle.
- enable dropped while avm_read=1 -> read completes, one sample_valid; no further reads. Re-enable -> first read after 8 cycles, velocity=0.
- reset_n pulsed low while waitrequest=1 -> avm_read=0 asynchronously, all outputs 0.
